// File: rtl/tmr_scrub_reg_if.sv
// Channel bundle for tmr_scrub_reg: write port, upset injection port, voted
// data output and the divergence-report valid/ready channel.
interface tmr_scrub_reg_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic               in_valid;
   logic [WIDTH-1:0]   in_data;
   logic [2:0]         inj_en;
   logic [WIDTH-1:0]   inj_mask;
   logic [WIDTH-1:0]   out_data;
   logic               err_valid;
   logic               err_ready;
   logic [2:0]         err_mask;
   logic               err_multi;
   logic [3*CNT_W-1:0] err_cnt;

   modport master (
      output in_valid, in_data, inj_en, inj_mask, err_ready,
      input  out_data, err_valid, err_mask, err_multi, err_cnt
   );

   modport slave (
      input  in_valid, in_data, inj_en, inj_mask, err_ready,
      output out_data, err_valid, err_mask, err_multi, err_cnt
   );
endinterface

// File: rtl/tmr_scrub_reg.sv
// Triplicated register with bitwise majority vote. Every cycle each replica is
// rewritten with the voted value (or new load data), so a single upset lives
// for one cycle only. Per-replica saturating upset counters and a valid/ready
// divergence report give the fault campaign visibility into what was repaired.
module tmr_scrub_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   tmr_scrub_reg_if.slave bus
);

   typedef enum logic {IDLE, REPORT} state_t;

   logic [WIDTH-1:0] r_q   [3];
   logic [WIDTH-1:0] r_d   [3];
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];
   logic [WIDTH-1:0] w_q, w_d;
   logic [WIDTH-1:0] vote;
   logic [2:0]       m;
   logic [2:0]       d;
   logic             multi_now;

   state_t           state_q, state_d;
   logic [2:0]       pend_mask_q, pend_mask_d;
   logic             pend_multi_q, pend_multi_d;
   logic [2:0]       err_mask_q, err_mask_d;
   logic             err_multi_q, err_multi_d;
   logic [2:0]       new_mask;
   logic             new_multi;
   logic             new_event;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                input logic inc);
      return (inc && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
   endfunction

   function automatic logic two_or_more(input logic [2:0] b);
      return (b[0] & b[1]) | (b[1] & b[2]) | (b[0] & b[2]);
   endfunction

   // Vote, per-replica mismatch, scrub/load/inject next values and counters.
   // With one shared injection mask the replicas hold at most two distinct
   // values, so a vote-relative mismatch never flags two replicas at once; a
   // double upset is instead judged against w_q, the value last written.
   always_comb begin
      vote = (r_q[0] & r_q[1]) | (r_q[1] & r_q[2]) | (r_q[0] & r_q[2]);
      w_d  = bus.in_valid ? bus.in_data : vote;
      m    = '0;
      d    = '0;
      for (int i = 0; i < 3; i++) begin
         m[i]     = (r_q[i] != vote);
         d[i]     = (r_q[i] != w_q);
         r_d[i]   = w_d ^ (bus.inj_en[i] ? bus.inj_mask : {WIDTH{1'b0}});
         cnt_d[i] = sat_inc(cnt_q[i], m[i]);
      end
      multi_now = two_or_more(d);
   end

   // Report FSM: IDLE latches the first divergence, REPORT holds it until
   // accepted while later divergences collect in the pending accumulator.
   // A triple same-bit upset leaves m clear but still raises multi, so it
   // also opens a report.
   always_comb begin
      new_mask     = pend_mask_q | m;
      new_multi    = pend_multi_q | multi_now;
      new_event    = (new_mask != 3'b000) || new_multi;
      state_d      = state_q;
      err_mask_d   = err_mask_q;
      err_multi_d  = err_multi_q;
      pend_mask_d  = new_mask;
      pend_multi_d = new_multi;
      case (state_q)
         IDLE: begin
            if (new_event) begin
               state_d      = REPORT;
               err_mask_d   = new_mask;
               err_multi_d  = new_multi;
               pend_mask_d  = '0;
               pend_multi_d = 1'b0;
            end
         end
         REPORT: begin
            if (bus.err_ready) begin
               pend_mask_d  = '0;
               pend_multi_d = 1'b0;
               if (new_event) begin
                  err_mask_d  = new_mask;
                  err_multi_d = new_multi;
               end else begin
                  state_d     = IDLE;
                  err_mask_d  = '0;
                  err_multi_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Replicas, counters, report state; rst clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            r_q[i]   <= '0;
            cnt_q[i] <= '0;
         end
         w_q          <= '0;
         state_q      <= IDLE;
         pend_mask_q  <= '0;
         pend_multi_q <= 1'b0;
         err_mask_q   <= '0;
         err_multi_q  <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            r_q[i]   <= r_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         w_q          <= w_d;
         state_q      <= state_d;
         pend_mask_q  <= pend_mask_d;
         pend_multi_q <= pend_multi_d;
         err_mask_q   <= err_mask_d;
         err_multi_q  <= err_multi_d;
      end
   end

   assign bus.out_data  = vote;
   assign bus.err_valid = (state_q == REPORT);
   assign bus.err_mask  = err_mask_q;
   assign bus.err_multi = err_multi_q;
   assign bus.err_cnt   = {cnt_q[2], cnt_q[1], cnt_q[0]};

endmodule
